// File: rtl/multicycle_control.sv
// Multicycle datapath sequencer: a Moore FSM that walks each instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                irWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                iorD,
  output logic                regWriteEnable,
  output logic                regDst,
  output logic                memToReg,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic [1:0]          pcSource,
  output logic [3:0]          state,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC     = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // State and retire counter registers; reset parks the machine in FETCH with a cleared count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state sequencing; an instruction retires on any re-entry into FETCH.
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    unique case (state_q)
      FETCH:    if (memReady) state_d = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = HALT;
        endcase
      end
      MEMADDR:  state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (memReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (memReady) state_d = FETCH;
      EXEC:     state_d = RTYPEWB;
      RTYPEWB:  state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ADDIEXEC: state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = HALT;
    endcase
    if ((state_d == FETCH) && (state_q != FETCH)) begin
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Per-state control decode; strobes are killed combinationally while reset is held.
  always_comb begin
    pcWrite        = 1'b0;
    irWrite        = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    iorD           = 1'b0;
    regWriteEnable = 1'b0;
    regDst         = 1'b0;
    memToReg       = 1'b0;
    aluSrcA        = 1'b0;
    aluSrcB        = 2'b00;
    aluOp          = 2'b00;
    pcSource       = 2'b00;
    halted         = 1'b0;
    unique case (state_q)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        pcWrite = memReady;
        irWrite = memReady;
      end
      DECODE:   aluSrcB = 2'b11;
      MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMREAD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEMWB: begin
        regWriteEnable = 1'b1;
        memToReg       = 1'b1;
      end
      MEMWRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
      end
      EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      RTYPEWB: begin
        regWriteEnable = 1'b1;
        regDst         = 1'b1;
      end
      BRANCH: begin
        aluSrcA  = 1'b1;
        aluOp    = 2'b01;
        pcSource = 2'b01;
        pcWrite  = zero;
      end
      ADDIEXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      ADDIWB:   regWriteEnable = 1'b1;
      JUMP: begin
        pcSource = 2'b10;
        pcWrite  = 1'b1;
      end
      HALT:     halted = 1'b1;
      default:  halted = 1'b1;
    endcase
    if (reset) begin
      pcWrite        = 1'b0;
      irWrite        = 1'b0;
      memRead        = 1'b0;
      memWrite       = 1'b0;
      regWriteEnable = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle variant of `DataPath`. It decodes the instruction-register opcode and steps a Moore FSM through fetch/decode/execute/memory/writeback. Each state drives the datapath mux selects and write strobes (`pcWrite`, `irWrite`, `regWriteEnable`, memory strobes). A ready handshake lets memory stall the sequence, and a retired-instruction counter supports bench cycle accounting.

## Interface
- `RETIRE_W`, default 32: width of retired-instruction counter.
- `clock`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  6  instr[31:26] from instruction register; valid from DECODE onward.
- `zero`  in  1  ALU zero flag; sampled combinationally in BRANCH.
- `memReady`  in  1  memory completes the current read/write this cycle.
- `pcWrite`  out  1  PC register load enable.
- `irWrite`  out  1  instruction register load enable.
- `memRead`, `memWrite`  out  1 each  memory strobes.
- `iorD`  out  1  memory address select: 0=PC, 1=ALUOut.
- `regWriteEnable`  out  1  register file write enable.
- `regDst`  out  1  write register select: 0=rt, 1=rd.
- `memToReg`  out  1  write data select: 0=ALUOut, 1=MDR.
- `aluSrcA`  out  1  0=PC, 1=regA.
- `aluSrcB`  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2.
- `aluOp`  out  2  00=add, 01=sub, 10=decode funct, 11 unused.
- `pcSource`  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- `state`  out  4  current FSM state code, debug.
- `halted`  out  1  FSM parked in HALT.
- `retired`  out  `RETIRE_W`  count of completed instructions.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RTYPEWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, HALT=12.
- Unlisted outputs are 0 in every state.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - pcWrite=irWrite=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADDR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - any other → HALT
- MEMADDR: aluSrcA=1, aluSrcB=10, aluOp=00 → MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: memRead=1, iorD=1; holds until memReady=1, then → MEMWB.
- MEMWB: regWriteEnable=1, regDst=0, memToReg=1 → FETCH.
- MEMWRITE: memWrite=1, iorD=1; holds until memReady=1, then → FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10 → RTYPEWB.
- RTYPEWB: regWriteEnable=1, regDst=1, memToReg=0 → FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=01, pcWrite=zero → FETCH.
- ADDIEXEC: aluSrcA=1, aluSrcB=10, aluOp=00 → ADDIWB.
- ADDIWB: regWriteEnable=1, regDst=0, memToReg=0 → FETCH.
- JUMP: pcSource=10, pcWrite=1 → FETCH.
- HALT: all strobes 0, halted=1; exits only via reset.
- retired increments by 1 on every transition into FETCH from a non-FETCH state. It wraps modulo 2^RETIRE_W and never increments from HALT.

## Timing
- Reset asserted: state=FETCH, retired=0, halted=0 immediately, without waiting for a clock edge. All strobes (pcWrite, irWrite, memRead, memWrite, regWriteEnable) are forced to 0 combinationally while reset=1.
- First FETCH cycle is the first rising edge after reset deasserts.
- All outputs are Moore decodes of state, except:
  - pcWrite/irWrite in FETCH, gated by memReady.
  - pcWrite in BRANCH, gated by zero.
- Cycles per instruction with memReady held 1:
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
  - Each memReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly 1 cycle.
- memReady is ignored in all other states.
- Reset mid-instruction aborts with no strobe pulse after assertion; retired is cleared.
- retired updates on the same edge as state enters FETCH.

## Test plan
- Reset, memReady=1, opcode=000000 held → state sequence 0,1,6,7,0 repeating; regWriteEnable=1 with regDst=1 only in state 7; retired=3 after 12 cycles.
- lw (100011) with memReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0; memToReg=1 and regWriteEnable=1 in state 4; retired=1.
- beq with zero=1 vs zero=0 → pcWrite=1 vs 0 in state 8; pcSource=01 both cases; 3 cycles each.
- sw then j → memWrite=1 with iorD=1 only in state 5; JUMP drives pcSource=10, pcWrite=1; retired=2 after 7 cycles.
- Illegal opcode 111111 → FETCH, DECODE, then HALT; halted=1 and all strobes 0 for 10+ cycles; retired unchanged; reset returns state=0, halted=0.
- Assert reset during MEMREAD between edges → memRead drops to 0 immediately, state=0, retired=0 before the next clock edge.
